hazard_stall_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage MIPS pipeline (F/D/E/M/W). It consumes the hazard-eval forwarding decisions' sibling information: load-use, branch-in-D dependencies, the multi-cycle mult/div unit, and memory-bus waits.
- Produces per-stage stall/bubble/flush controls.
- Owns the mult/div busy FSM, the instruction-fetch discard FSM after flushes, and a stall-cycle counter.

---
 rtl/hazard_stall_ctrl.sv | 130 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage F/D/E/M/W pipeline. It also owns the
// mult/div busy tracker, the post-flush fetch-discard tracker and a stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic             use_rs_d,
  input  logic             use_rt_d,
  input  logic             branch_d,
  input  logic             hilo_read_d,
  input  logic             reg_write_en_e,
  input  logic             reg_write_en_m,
  input  logic [4:0]       reg_write_dst_e,
  input  logic [4:0]       reg_write_dst_m,
  input  logic             load_e,
  input  logic             load_m,
  input  logic             md_start_e,
  input  logic             md_is_div_e,
  input  logic             imem_req,
  input  logic             imem_data_ok,
  input  logic             dmem_req_m,
  input  logic             dmem_data_ok,
  input  logic             exc_flush,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             bubble_d,
  output logic             bubble_e,
  output logic             bubble_w,
  output logic             flush_all,
  output logic             md_busy,
  output logic             imem_discard,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MAX_LAT = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int MD_W    = $clog2(MAX_LAT + 1);

  typedef enum logic {MD_IDLE, MD_RUN} md_state_e;
  typedef enum logic {DS_IDLE, DS_DISCARD} ds_state_e;

  md_state_e        md_state_q;
  logic [MD_W-1:0]  md_cnt_q;
  ds_state_e        ds_state_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic dep_e, dep_m, lu, br, md_hold, dmem_wait, fetch_wait, md_run, ds_active;

  always_comb begin
    dep_e = reg_write_en_e && (reg_write_dst_e != 5'd0) &&
            ((use_rs_d && reg_write_dst_e == rs_d) || (use_rt_d && reg_write_dst_e == rt_d));
    dep_m = reg_write_en_m && (reg_write_dst_m != 5'd0) &&
            ((use_rs_d && reg_write_dst_m == rs_d) || (use_rt_d && reg_write_dst_m == rt_d));
    lu         = load_e && dep_e;
    // ALU producers are forwarded, so only loads hold a branch in D
    br         = branch_d && ((dep_e && load_e) || (dep_m && load_m));
    md_run     = (md_state_q == MD_RUN);
    ds_active  = (ds_state_q == DS_DISCARD);
    md_hold    = md_run && (hilo_read_d || md_start_e);
    dmem_wait  = dmem_req_m && !dmem_data_ok;
    fetch_wait = (imem_req && !imem_data_ok) || ds_active;

    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    bubble_d  = 1'b0;
    bubble_e  = 1'b0;
    bubble_w  = 1'b0;
    flush_all = 1'b0;
    if (reset) begin
      flush_all = 1'b0;
    end else if (exc_flush) begin
      flush_all = 1'b1;
    end else if (dmem_wait) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      stall_e  = 1'b1;
      stall_m  = 1'b1;
      bubble_w = 1'b1;
    end else if (lu || br || md_hold) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      bubble_e = 1'b1;
    end else if (fetch_wait) begin
      stall_f  = 1'b1;
      bubble_d = 1'b1;
    end
    md_busy      = md_run && !reset;
    imem_discard = ds_active && !reset;
  end

  assign stall_cycles = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      md_state_q  <= MD_IDLE;
      md_cnt_q    <= '0;
      ds_state_q  <= DS_IDLE;
      stall_cnt_q <= '0;
    end else begin
      // A running op has already committed, so neither flush nor a new start disturbs it
      if (md_state_q == MD_IDLE) begin
        if (md_start_e && !stall_e && !exc_flush) begin
          md_state_q <= MD_RUN;
          md_cnt_q   <= md_is_div_e ? MD_W'(DIV_CYCLES - 1) : MD_W'(MULT_CYCLES - 1);
        end
      end else if (md_cnt_q == '0) begin
        md_state_q <= MD_IDLE;
      end else begin
        md_cnt_q <= md_cnt_q - MD_W'(1);
      end

      if (ds_state_q == DS_IDLE) begin
        if (flush_all && imem_req && !imem_data_ok) ds_state_q <= DS_DISCARD;
      end else if (!flush_all && imem_data_ok) begin
        ds_state_q <= DS_IDLE;
      end

      if (stall_d && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed plus randomized bench for hazard_stall_ctrl, checked every cycle
// against a cycle-count based reference model.
module tb_hazard_stall_ctrl;
  localparam int MULT = 4;
  localparam int DIV  = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs_d, rt_d, reg_write_dst_e, reg_write_dst_m;
  logic use_rs_d, use_rt_d, branch_d, hilo_read_d, reg_write_en_e, reg_write_en_m;
  logic load_e, load_m, md_start_e, md_is_div_e, imem_req, imem_data_ok;
  logic dmem_req_m, dmem_data_ok, exc_flush;
  logic stall_f, stall_d, stall_e, stall_m, bubble_d, bubble_e, bubble_w, flush_all;
  logic md_busy, imem_discard;
  logic [CW-1:0] stall_cycles;

  int checks = 0;
  int errors = 0;
  int md_rem = 0;
  bit disc_pend = 0;
  int cnt = -1;
  logic obs_busy, obs_disc;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
    .branch_d(branch_d), .hilo_read_d(hilo_read_d), .reg_write_en_e(reg_write_en_e),
    .reg_write_en_m(reg_write_en_m), .reg_write_dst_e(reg_write_dst_e),
    .reg_write_dst_m(reg_write_dst_m), .load_e(load_e), .load_m(load_m),
    .md_start_e(md_start_e), .md_is_div_e(md_is_div_e), .imem_req(imem_req),
    .imem_data_ok(imem_data_ok), .dmem_req_m(dmem_req_m), .dmem_data_ok(dmem_data_ok),
    .exc_flush(exc_flush), .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .stall_m(stall_m), .bubble_d(bubble_d), .bubble_e(bubble_e), .bubble_w(bubble_w),
    .flush_all(flush_all), .md_busy(md_busy), .imem_discard(imem_discard),
    .stall_cycles(stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit reads(input logic [4:0] r);
    return (r != 5'd0) && ((use_rs_d && rs_d == r) || (use_rt_d && rt_d == r));
  endfunction

  task automatic clr();
    reset = 0; rs_d = 0; rt_d = 0; use_rs_d = 0; use_rt_d = 0; branch_d = 0; hilo_read_d = 0;
    reg_write_en_e = 0; reg_write_en_m = 0; reg_write_dst_e = 0; reg_write_dst_m = 0;
    load_e = 0; load_m = 0; md_start_e = 0; md_is_div_e = 0; imem_req = 0; imem_data_ok = 0;
    dmem_req_m = 0; dmem_data_ok = 0; exc_flush = 0;
  endtask

  // Entered 1 time unit after a rising edge with inputs applied; compares at the
  // falling edge, then advances the model across the next rising edge.
  task automatic cycle();
    int mode;  // 0 none, 1 flush, 2 memory wait, 3 hazard, 4 fetch wait
    bit e_sf, e_sd, e_se, e_sm, e_bd, e_be, e_bw, e_fl, busy;
    logic [7:0] exp_v, obs_v;
    #4;
    busy = (md_rem > 0);
    if (reset) mode = 0;
    else if (exc_flush) mode = 1;
    else if (dmem_req_m && !dmem_data_ok) mode = 2;
    else if ((load_e && reg_write_en_e && reads(reg_write_dst_e)) ||
             (branch_d && ((load_e && reg_write_en_e && reads(reg_write_dst_e)) ||
                           (load_m && reg_write_en_m && reads(reg_write_dst_m)))) ||
             (busy && (hilo_read_d || md_start_e))) mode = 3;
    else if ((imem_req && !imem_data_ok) || disc_pend) mode = 4;
    else mode = 0;
    e_fl = (mode == 1);
    e_sf = (mode >= 2);
    e_sd = (mode == 2 || mode == 3);
    e_se = (mode == 2); e_sm = e_se; e_bw = e_se;
    e_be = (mode == 3);
    e_bd = (mode == 4);
    exp_v = {e_sf, e_sd, e_se, e_sm, e_bd, e_be, e_bw, e_fl};
    obs_v = {stall_f, stall_d, stall_e, stall_m, bubble_d, bubble_e, bubble_w, flush_all};
    chk("ctrl", {24'd0, obs_v}, {24'd0, exp_v});
    chk("md_busy", {31'd0, md_busy}, {31'd0, busy && !reset});
    chk("imem_discard", {31'd0, imem_discard}, {31'd0, disc_pend && !reset});
    if (cnt >= 0) chk("stall_cycles", {28'd0, stall_cycles}, cnt);
    obs_busy = md_busy;
    obs_disc = imem_discard;
    @(posedge clk);
    if (reset) begin
      md_rem = 0; disc_pend = 0; cnt = 0;
    end else begin
      if (md_rem > 0) md_rem--;
      else if (md_start_e && !e_se && !exc_flush) md_rem = md_is_div_e ? DIV : MULT;
      if (disc_pend) begin
        if (!exc_flush && imem_data_ok) disc_pend = 0;
      end else if (exc_flush && imem_req && !imem_data_ok) disc_pend = 1;
      if (e_sd && cnt >= 0 && cnt < CMAX) cnt++;
    end
    #1;
  endtask

  task automatic do_reset();
    clr(); reset = 1; cycle(); reset = 0;
  endtask

  initial begin
    int n;
    clr();
    @(posedge clk); #1;
    reset = 1; cycle(); cycle(); reset = 0;
    chk("reset_cnt", {28'd0, stall_cycles}, 0);

    // Load-use: one stall cycle, then the load in M does not stall a non-branch
    load_e = 1; reg_write_en_e = 1; reg_write_dst_e = 9; use_rs_d = 1; rs_d = 9; cycle();
    load_e = 0; reg_write_en_e = 0; load_m = 1; reg_write_en_m = 1; reg_write_dst_m = 9; cycle();
    clr(); cycle();
    chk("lu_cnt", {28'd0, stall_cycles}, 1);

    // Branch after load stalls twice; ALU producer and $0 producer never stall
    branch_d = 1; use_rs_d = 1; rs_d = 9;
    load_e = 1; reg_write_en_e = 1; reg_write_dst_e = 9; cycle();
    load_e = 0; reg_write_en_e = 0; load_m = 1; reg_write_en_m = 1; reg_write_dst_m = 9; cycle();
    load_m = 0; reg_write_en_m = 0; cycle();
    chk("br_load_cnt", {28'd0, stall_cycles}, 3);
    reg_write_en_e = 1; reg_write_dst_e = 9; cycle();
    reg_write_en_e = 0; reg_write_en_m = 1; reg_write_dst_m = 9; cycle();
    reg_write_en_m = 0; load_e = 1; reg_write_en_e = 1; reg_write_dst_e = 0; rs_d = 0; cycle();
    chk("br_alu_cnt", {28'd0, stall_cycles}, 3);

    // Divide then mfhi held in D: busy for DIV cycles
    do_reset();
    md_start_e = 1; md_is_div_e = 1; cycle();
    clr(); hilo_read_d = 1; n = 0;
    for (int i = 0; i < 40; i++) begin cycle(); if (obs_busy === 1'b1) n++; end
    chk("div_busy_len", n, DIV);
    clr(); md_start_e = 1; cycle();
    clr(); n = 0;
    for (int i = 0; i < 8; i++) begin cycle(); if (obs_busy === 1'b1) n++; end
    chk("mult_busy_len", n, MULT);

    // Memory wait over a pending load-use
    do_reset();
    load_e = 1; reg_write_en_e = 1; reg_write_dst_e = 5; use_rt_d = 1; rt_d = 5;
    dmem_req_m = 1;
    for (int i = 0; i < 3; i++) cycle();
    dmem_data_ok = 1; cycle();
    clr(); cycle();
    chk("dmem_cnt", {28'd0, stall_cycles}, 4);

    // Flush with a fetch in flight, then a flush coinciding with data return
    do_reset();
    exc_flush = 1; imem_req = 1; cycle();
    exc_flush = 0; imem_req = 0; cycle();
    chk("disc_wait", {31'd0, obs_disc}, 1);
    imem_data_ok = 1; cycle();
    chk("disc_drop", {31'd0, obs_disc}, 1);
    imem_data_ok = 0; cycle();
    chk("disc_idle", {31'd0, obs_disc}, 0);
    exc_flush = 1; imem_req = 1; imem_data_ok = 1; cycle();
    clr(); cycle();
    chk("flush_ok_nodisc", {31'd0, obs_disc}, 0);

    // Reset in the middle of a divide
    md_start_e = 1; md_is_div_e = 1; cycle();
    clr();
    for (int i = 0; i < 21; i++) cycle();
    reset = 1; cycle(); reset = 0; cycle();
    chk("rst_run_busy", {31'd0, obs_busy}, 0);

    // Saturation of the 4-bit stall counter
    load_e = 1; reg_write_en_e = 1; reg_write_dst_e = 3; use_rs_d = 1; rs_d = 3;
    for (int i = 0; i < 20; i++) cycle();
    clr(); cycle();
    chk("sat_cnt", {28'd0, stall_cycles}, CMAX);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
      use_rs_d = 1'($urandom); use_rt_d = 1'($urandom);
      branch_d = ($urandom_range(0, 3) == 0); hilo_read_d = ($urandom_range(0, 3) == 0);
      reg_write_en_e = 1'($urandom); reg_write_en_m = 1'($urandom);
      reg_write_dst_e = 5'($urandom_range(0, 3)); reg_write_dst_m = 5'($urandom_range(0, 3));
      load_e = ($urandom_range(0, 2) == 0); load_m = ($urandom_range(0, 2) == 0);
      md_start_e = ($urandom_range(0, 7) == 0); md_is_div_e = ($urandom_range(0, 3) == 0);
      imem_req = 1'($urandom); imem_data_ok = 1'($urandom);
      dmem_req_m = ($urandom_range(0, 3) == 0); dmem_data_ok = 1'($urandom);
      exc_flush = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
